// File: rtl/writeback_arbiter_pkg.sv
// Shared core constants and the buffered multi-cycle result record for
// the writeback arbiter slice.
package writeback_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;
    localparam logic [REG_ADDR_W-1:0] X0 = 5'd0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_entry_t;

    // One-hot register mask; x0 never appears in the scoreboard.
    function automatic logic [31:0] rd_onehot(input logic [REG_ADDR_W-1:0] rd);
        logic [31:0] mask;
        mask = 32'd1 << rd;
        mask[0] = 1'b0;
        return mask;
    endfunction

endpackage

// File: rtl/wb_result_fifo.sv
// Small circular buffer holding multi-cycle results that lost the write
// port. Pointers wrap naturally because DEPTH is a power of two.
module wb_result_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 37
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (count_r == CNT_W'(DEPTH));
    assign empty     = (count_r == {CNT_W{1'b0}});
    assign head      = mem_r[rd_ptr_r];
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;

    // Entry storage; contents are meaningless while the occupancy says empty.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; reset drops every buffered entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + 1'b1;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/writeback_arbiter.sv
// Owner of the register-file write port: merges ALU and MDU results,
// buffers losing MDU results, forces a hold when the buffer starves and
// tracks destinations of in-flight multi-cycle ops for decode stalls.
module writeback_arbiter
    import writeback_arbiter_pkg::*;
#(
    parameter int BUF_DEPTH    = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alu_valid,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [XLEN-1:0]       alu_data,
    input  logic                  mc_issue,
    input  logic [REG_ADDR_W-1:0] mc_issue_rd,
    input  logic                  mc_result_valid,
    input  logic [REG_ADDR_W-1:0] mc_result_rd,
    input  logic [XLEN-1:0]       mc_result_data,
    output logic                  mc_result_ready,
    input  logic [REG_ADDR_W-1:0] dec_rs1,
    input  logic [REG_ADDR_W-1:0] dec_rs2,
    input  logic [REG_ADDR_W-1:0] dec_rd,
    output logic                  dec_busy,
    output logic                  pipe_hold,
    output logic                  rf_write_en,
    output logic [REG_ADDR_W-1:0] rf_write_rd,
    output logic [XLEN-1:0]       rf_write_data
);

    localparam int STARVE_W = $clog2(STARVE_LIMIT) + 1;
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT - 1);

    wb_entry_t             push_entry_s;
    wb_entry_t             head_s;
    logic                  fifo_full_s;
    logic                  fifo_empty_s;
    logic                  push_s;
    logic                  sel_alu_s;
    logic                  sel_buf_s;
    logic                  wait_s;
    logic [31:0]           set_mask_s;
    logic [31:0]           clr_mask_s;
    logic [31:0]           pending_r;
    logic [STARVE_W-1:0]   starve_cnt_r;
    logic                  pipe_hold_r;
    logic                  rf_write_en_r;
    logic [REG_ADDR_W-1:0] rf_write_rd_r;
    logic [XLEN-1:0]       rf_write_data_r;

    // rd==0 MDU results are handshaken but never stored.
    assign mc_result_ready = rst_n && !fifo_full_s;
    assign push_s          = mc_result_valid && mc_result_ready && (mc_result_rd != X0);
    assign push_entry_s    = '{rd: mc_result_rd, data: mc_result_data};

    wb_result_fifo #(
        .DEPTH (BUF_DEPTH),
        .WIDTH ($bits(wb_entry_t))
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_s),
        .push_data (push_entry_s),
        .pop       (sel_buf_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .head      (head_s)
    );

    // Write-port arbitration: a hold cycle belongs to the buffer, otherwise ALU first.
    always_comb begin
        sel_alu_s = 1'b0;
        sel_buf_s = 1'b0;
        if (pipe_hold_r) begin
            sel_buf_s = !fifo_empty_s;
        end else if (alu_valid && (alu_rd != X0)) begin
            sel_alu_s = 1'b1;
        end else if (!fifo_empty_s) begin
            sel_buf_s = 1'b1;
        end else begin
            sel_alu_s = 1'b0;
            sel_buf_s = 1'b0;
        end
    end

    assign wait_s = !fifo_empty_s && !sel_buf_s;

    // Scoreboard masks: a same-cycle issue to the written rd re-sets the bit.
    always_comb begin
        set_mask_s = 32'd0;
        clr_mask_s = 32'd0;
        if (mc_issue && (mc_issue_rd != X0)) begin
            set_mask_s = rd_onehot(mc_issue_rd);
        end else begin
            set_mask_s = 32'd0;
        end
        if (sel_buf_s) begin
            clr_mask_s = rd_onehot(head_s.rd);
        end else begin
            clr_mask_s = 32'd0;
        end
    end

    // Starvation counter; the hold fires after STARVE_LIMIT waiting cycles and
    // lasts one cycle because the forced pop clears the count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_cnt_r <= {STARVE_W{1'b0}};
            pipe_hold_r  <= 1'b0;
        end else begin
            if (wait_s) begin
                if (starve_cnt_r != STARVE_MAX) begin
                    starve_cnt_r <= starve_cnt_r + 1'b1;
                end
            end else begin
                starve_cnt_r <= {STARVE_W{1'b0}};
            end
            pipe_hold_r <= wait_s && (starve_cnt_r == STARVE_MAX);
        end
    end

    // Pending-destination scoreboard for in-flight multi-cycle ops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending_r <= 32'd0;
        end else begin
            pending_r <= (pending_r & ~clr_mask_s) | set_mask_s;
        end
    end

    // Registered register-file write port.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rf_write_en_r   <= 1'b0;
            rf_write_rd_r   <= X0;
            rf_write_data_r <= 32'd0;
        end else begin
            rf_write_en_r <= sel_alu_s || sel_buf_s;
            if (sel_alu_s) begin
                rf_write_rd_r   <= alu_rd;
                rf_write_data_r <= alu_data;
            end else if (sel_buf_s) begin
                rf_write_rd_r   <= head_s.rd;
                rf_write_data_r <= head_s.data;
            end
        end
    end

    assign dec_busy      = pending_r[dec_rs1] | pending_r[dec_rs2] | pending_r[dec_rd];
    assign pipe_hold     = pipe_hold_r;
    assign rf_write_en   = rf_write_en_r;
    assign rf_write_rd   = rf_write_rd_r;
    assign rf_write_data = rf_write_data_r;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: reset, ALU path, scoreboard,
// conflict/starvation, same-cycle set/clear and mid-operation reset.
module tb_writeback_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        mc_issue;
    logic [4:0]  mc_issue_rd;
    logic        mc_result_valid;
    logic [4:0]  mc_result_rd;
    logic [31:0] mc_result_data;
    logic        mc_result_ready;
    logic [4:0]  dec_rs1;
    logic [4:0]  dec_rs2;
    logic [4:0]  dec_rd;
    logic        dec_busy;
    logic        pipe_hold;
    logic        rf_write_en;
    logic [4:0]  rf_write_rd;
    logic [31:0] rf_write_data;

    int n_tests = 0;
    int n_fail  = 0;

    writeback_arbiter #(.BUF_DEPTH(2), .STARVE_LIMIT(8)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .alu_valid       (alu_valid),
        .alu_rd          (alu_rd),
        .alu_data        (alu_data),
        .mc_issue        (mc_issue),
        .mc_issue_rd     (mc_issue_rd),
        .mc_result_valid (mc_result_valid),
        .mc_result_rd    (mc_result_rd),
        .mc_result_data  (mc_result_data),
        .mc_result_ready (mc_result_ready),
        .dec_rs1         (dec_rs1),
        .dec_rs2         (dec_rs2),
        .dec_rd          (dec_rd),
        .dec_busy        (dec_busy),
        .pipe_hold       (pipe_hold),
        .rf_write_en     (rf_write_en),
        .rf_write_rd     (rf_write_rd),
        .rf_write_data   (rf_write_data)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
        mc_issue = 1'b0; mc_issue_rd = 5'd0;
        mc_result_valid = 1'b0; mc_result_rd = 5'd0; mc_result_data = 32'd0;
        dec_rs1 = 5'd0; dec_rs2 = 5'd0; dec_rd = 5'd0;
        step();
        step();
        n_tests++; if (rf_write_en !== 1'b0) begin n_fail++; $display("FAIL reset_en got %b want 0", rf_write_en); end
        n_tests++; if (rf_write_rd !== 5'd0) begin n_fail++; $display("FAIL reset_rd got %0d want 0", rf_write_rd); end
        n_tests++; if (rf_write_data !== 32'd0) begin n_fail++; $display("FAIL reset_data got %h want 0", rf_write_data); end
        n_tests++; if (pipe_hold !== 1'b0) begin n_fail++; $display("FAIL reset_hold got %b want 0", pipe_hold); end
        n_tests++; if (dec_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", dec_busy); end
        n_tests++; if (mc_result_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready_low got %b want 0", mc_result_ready); end
        rst_n = 1'b1;
        #1;
        n_tests++; if (mc_result_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_release got %b want 1", mc_result_ready); end
        step();
    endtask

    task automatic test_alu();
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        step();
        n_tests++; if (rf_write_en !== 1'b1) begin n_fail++; $display("FAIL alu_en got %b want 1", rf_write_en); end
        n_tests++; if (rf_write_rd !== 5'd5) begin n_fail++; $display("FAIL alu_rd got %0d want 5", rf_write_rd); end
        n_tests++; if (rf_write_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL alu_data got %h want deadbeef", rf_write_data); end
        alu_rd = 5'd0; alu_data = 32'h12345678;
        step();
        n_tests++; if (rf_write_en !== 1'b0) begin n_fail++; $display("FAIL alu_rd0_en got %b want 0", rf_write_en); end
        alu_valid = 1'b0;
        step();
    endtask

    task automatic test_scoreboard();
        mc_issue = 1'b1; mc_issue_rd = 5'd7;
        step();
        mc_issue = 1'b0; dec_rs1 = 5'd7;
        #1;
        n_tests++; if (dec_busy !== 1'b1) begin n_fail++; $display("FAIL sb_busy_set got %b want 1", dec_busy); end
        mc_result_valid = 1'b1; mc_result_rd = 5'd7; mc_result_data = 32'd42;
        #1;
        n_tests++; if (mc_result_ready !== 1'b1) begin n_fail++; $display("FAIL sb_ready got %b want 1", mc_result_ready); end
        step();
        mc_result_valid = 1'b0;
        n_tests++; if (rf_write_en !== 1'b0) begin n_fail++; $display("FAIL sb_no_bypass got %b want 0", rf_write_en); end
        n_tests++; if (dec_busy !== 1'b1) begin n_fail++; $display("FAIL sb_busy_hold got %b want 1", dec_busy); end
        step();
        n_tests++; if (rf_write_en !== 1'b1 || rf_write_rd !== 5'd7) begin n_fail++; $display("FAIL sb_write got en=%b rd=%0d want en=1 rd=7", rf_write_en, rf_write_rd); end
        n_tests++; if (rf_write_data !== 32'd42) begin n_fail++; $display("FAIL sb_data got %0d want 42", rf_write_data); end
        n_tests++; if (dec_busy !== 1'b0) begin n_fail++; $display("FAIL sb_busy_clear got %b want 0", dec_busy); end
        dec_rs1 = 5'd0;
        step();
        n_tests++; if (rf_write_en !== 1'b0) begin n_fail++; $display("FAIL sb_idle got %b want 0", rf_write_en); end
    endtask

    task automatic test_conflict();
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h33;
        mc_result_valid = 1'b1; mc_result_rd = 5'd9; mc_result_data = 32'h99;
        step();
        mc_result_rd = 5'd10; mc_result_data = 32'hAA;
        #1;
        n_tests++; if (mc_result_ready !== 1'b1) begin n_fail++; $display("FAIL cf_ready_second got %b want 1", mc_result_ready); end
        step();
        mc_result_rd = 5'd11; mc_result_data = 32'hBB;
        #1;
        n_tests++; if (mc_result_ready !== 1'b0) begin n_fail++; $display("FAIL cf_ready_full got %b want 0", mc_result_ready); end
        mc_result_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            n_tests++; if (pipe_hold !== 1'b0 || rf_write_rd !== 5'd3) begin n_fail++; $display("FAIL cf_wait[%0d] got hold=%b rd=%0d want hold=0 rd=3", i, pipe_hold, rf_write_rd); end
        end
        step();
        n_tests++; if (pipe_hold !== 1'b1) begin n_fail++; $display("FAIL cf_hold_rise got %b want 1", pipe_hold); end
        n_tests++; if (rf_write_en !== 1'b1 || rf_write_rd !== 5'd3) begin n_fail++; $display("FAIL cf_alu_before_hold got en=%b rd=%0d want en=1 rd=3", rf_write_en, rf_write_rd); end
        step();
        n_tests++; if (pipe_hold !== 1'b0) begin n_fail++; $display("FAIL cf_hold_fall got %b want 0", pipe_hold); end
        n_tests++; if (rf_write_en !== 1'b1 || rf_write_rd !== 5'd9 || rf_write_data !== 32'h99) begin n_fail++; $display("FAIL cf_rd9 got en=%b rd=%0d data=%h want en=1 rd=9 data=99", rf_write_en, rf_write_rd, rf_write_data); end
        alu_valid = 1'b0;
        step();
        n_tests++; if (rf_write_en !== 1'b1 || rf_write_rd !== 5'd10 || rf_write_data !== 32'hAA) begin n_fail++; $display("FAIL cf_rd10 got en=%b rd=%0d data=%h want en=1 rd=10 data=aa", rf_write_en, rf_write_rd, rf_write_data); end
        step();
        n_tests++; if (rf_write_en !== 1'b0) begin n_fail++; $display("FAIL cf_drained got %b want 0", rf_write_en); end
    endtask

    task automatic test_same_cycle();
        mc_issue = 1'b1; mc_issue_rd = 5'd12;
        step();
        mc_issue = 1'b0;
        mc_result_valid = 1'b1; mc_result_rd = 5'd12; mc_result_data = 32'h1212;
        step();
        mc_result_valid = 1'b0;
        mc_issue = 1'b1; mc_issue_rd = 5'd12;
        step();
        mc_issue = 1'b0; dec_rs2 = 5'd12;
        #1;
        n_tests++; if (rf_write_en !== 1'b1 || rf_write_rd !== 5'd12) begin n_fail++; $display("FAIL sc_write got en=%b rd=%0d want en=1 rd=12", rf_write_en, rf_write_rd); end
        n_tests++; if (dec_busy !== 1'b1) begin n_fail++; $display("FAIL sc_set_wins got %b want 1", dec_busy); end
        step();
    endtask

    task automatic test_reset_mid();
        mc_issue = 1'b1; mc_issue_rd = 5'd20;
        step();
        mc_issue_rd = 5'd21;
        step();
        mc_issue = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h33;
        mc_result_valid = 1'b1; mc_result_rd = 5'd20; mc_result_data = 32'h20;
        step();
        mc_result_rd = 5'd21; mc_result_data = 32'h21;
        step();
        mc_result_valid = 1'b0;
        dec_rs1 = 5'd20; dec_rd = 5'd21;
        #1;
        n_tests++; if (dec_busy !== 1'b1) begin n_fail++; $display("FAIL rm_busy_before got %b want 1", dec_busy); end
        n_tests++; if (mc_result_ready !== 1'b0) begin n_fail++; $display("FAIL rm_full_before got %b want 0", mc_result_ready); end
        rst_n = 1'b0; alu_valid = 1'b0;
        step();
        n_tests++; if (dec_busy !== 1'b0) begin n_fail++; $display("FAIL rm_busy_cleared got %b want 0", dec_busy); end
        n_tests++; if (rf_write_en !== 1'b0) begin n_fail++; $display("FAIL rm_en_reset got %b want 0", rf_write_en); end
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_tests++; if (rf_write_en !== 1'b0) begin n_fail++; $display("FAIL rm_stale[%0d] got %b want 0", i, rf_write_en); end
        end
        n_tests++; if (mc_result_ready !== 1'b1) begin n_fail++; $display("FAIL rm_ready_after got %b want 1", mc_result_ready); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_scoreboard();
        test_conflict();
        test_same_cycle();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
